// File: rtl/pec_ram_fifo_ctrl_if.sv
// pec_ram_fifo_ctrl_if: push/pop handshakes, RAM strobes and status of the PEC RAM FIFO controller
//   push_valid/push_ready/push_data : upstream valid/ready stream
//   pop_valid/pop_ready/pop_data    : downstream valid/ready stream
//   ram_addr_w/ram_addr_r/ram_write_en/ram_read_en/ram_data_in/ram_data_out : single-port RAM side
//   fifo_cnt/full/empty             : occupancy status
//   slave modport = controller side, master modport = environment side
interface pec_ram_fifo_ctrl_if #(
   parameter int DEPTH_BIT  = 6,
   parameter int DATA_WIDTH = 28
);
   logic                  push_valid;
   logic                  push_ready;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  pop_valid;
   logic                  pop_ready;
   logic [DATA_WIDTH-1:0] pop_data;
   logic [DEPTH_BIT-1:0]  ram_addr_w;
   logic [DEPTH_BIT-1:0]  ram_addr_r;
   logic                  ram_write_en;
   logic                  ram_read_en;
   logic [DATA_WIDTH-1:0] ram_data_in;
   logic [DATA_WIDTH-1:0] ram_data_out;
   logic [DEPTH_BIT:0]    fifo_cnt;
   logic                  full;
   logic                  empty;
   modport slave (
      input  push_valid, push_data, pop_ready, ram_data_out,
      output push_ready, pop_valid, pop_data, ram_addr_w, ram_addr_r,
             ram_write_en, ram_read_en, ram_data_in, fifo_cnt, full, empty
   );
   modport master (
      output push_valid, push_data, pop_ready, ram_data_out,
      input  push_ready, pop_valid, pop_data, ram_addr_w, ram_addr_r,
             ram_write_en, ram_read_en, ram_data_in, fifo_cnt, full, empty
   );
endinterface

// File: rtl/pec_ram_fifo_ctrl.sv
// pec_ram_fifo_ctrl: FIFO controller in front of the single-port partial-sum RAM, with a 2-entry output skid buffer
//   clk, rst : clock, synchronous active-high reset
//   bus      : pec_ram_fifo_ctrl_if.slave (push stream, pop stream, RAM strobes/addresses/data, fifo_cnt/full/empty)
//   PEC_FIFO_BYPASS_EN : when defined, pushes into an otherwise empty pipeline go straight to the output buffer
module pec_ram_fifo_ctrl #(
   parameter int DEPTH_BIT  = 6,
   parameter int DATA_WIDTH = 28
) (
   input logic                clk,
   input logic                rst,
   pec_ram_fifo_ctrl_if.slave bus
);
   logic [DEPTH_BIT-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BIT:0]    ram_cnt_q, ram_cnt_d, fifo_cnt;
   logic                  rd_inflight_q, rd_inflight_d, prio_rd_q, prio_rd_d;
   logic [1:0]            ob_cnt_q, ob_cnt_d;
   logic                  ob_head_q, ob_head_d, ob_tail;
   logic [DATA_WIDTH-1:0] ob_data_q [2];
   logic [DATA_WIDTH-1:0] ob_data_d [2];
   logic                  full, rd_req, push_ready, pop_valid, wr_go, rd_go, byp, cap, pop, conflict;
   logic [DATA_WIDTH-1:0] cap_data;
   always_comb begin
      // ram_cnt never exceeds DEPTH, so its MSB alone means full
      full          = ram_cnt_q[DEPTH_BIT];
      // a read is only issued if its return is guaranteed a free output-buffer slot
      rd_req        = !rst && ram_cnt_q != '0 && (ob_cnt_q + 2'(rd_inflight_q)) < 2'd2;
`ifdef PEC_FIFO_BYPASS_EN
      byp           = !rst && bus.push_valid && ram_cnt_q == '0 && !rd_inflight_q && ob_cnt_q != 2'd2;
`else
      byp           = 1'b0;
`endif
      push_ready    = !rst && (byp || (!full && !(rd_req && prio_rd_q)));
      wr_go         = bus.push_valid && push_ready && !byp;
      rd_go         = rd_req && !wr_go;
      conflict      = bus.push_valid && !full && rd_req;
      prio_rd_d     = prio_rd_q ^ conflict;
      wr_ptr_d      = wr_ptr_q + DEPTH_BIT'(wr_go);
      rd_ptr_d      = rd_ptr_q + DEPTH_BIT'(rd_go);
      ram_cnt_d     = ram_cnt_q + (DEPTH_BIT+1)'(wr_go) - (DEPTH_BIT+1)'(rd_go);
      rd_inflight_d = rd_go;
      pop_valid     = !rst && ob_cnt_q != 2'd0;
      pop           = pop_valid && bus.pop_ready;
      // bypass never coincides with a read return (it requires no read in flight)
      cap           = rd_inflight_q || byp;
      cap_data      = byp ? bus.push_data : bus.ram_data_out;
      // capture never happens with two entries held, so bit 0 of the count picks the tail slot
      ob_tail       = ob_head_q ^ ob_cnt_q[0];
      ob_data_d[0]  = (cap && !ob_tail) ? cap_data : ob_data_q[0];
      ob_data_d[1]  = (cap && ob_tail) ? cap_data : ob_data_q[1];
      ob_head_d     = ob_head_q ^ pop;
      ob_cnt_d      = ob_cnt_q + 2'(cap) - 2'(pop);
      fifo_cnt      = ram_cnt_q + (DEPTH_BIT+1)'(rd_inflight_q) + (DEPTH_BIT+1)'(ob_cnt_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         ram_cnt_q     <= '0;
         rd_inflight_q <= 1'b0;
         prio_rd_q     <= 1'b0;
         ob_cnt_q      <= '0;
         ob_head_q     <= 1'b0;
         ob_data_q     <= '{default: '0};
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         ram_cnt_q     <= ram_cnt_d;
         rd_inflight_q <= rd_inflight_d;
         prio_rd_q     <= prio_rd_d;
         ob_cnt_q      <= ob_cnt_d;
         ob_head_q     <= ob_head_d;
         ob_data_q     <= ob_data_d;
      end
   end
   assign bus.push_ready   = push_ready;
   assign bus.pop_valid    = pop_valid;
   assign bus.pop_data     = ob_data_q[ob_head_q];
   assign bus.ram_addr_w   = wr_ptr_q;
   assign bus.ram_addr_r   = rd_ptr_q;
   assign bus.ram_write_en = wr_go;
   assign bus.ram_read_en  = rd_go;
   assign bus.ram_data_in  = bus.push_data;
   assign bus.fifo_cnt     = fifo_cnt;
   assign bus.full         = !rst && full;
   assign bus.empty        = rst || fifo_cnt == '0;
endmodule

// File: doc/pec_ram_fifo_ctrl.md
Name: pec_ram_fifo_ctrl

Overview:
- FIFO controller placed in front of the PEC single-port partial-sum RAM wrapper.
- Converts a valid/ready push stream and a valid/ready pop stream into RAM address and enable strobes.
- One RAM access per cycle, either a read or a write. Write/read conflicts are arbitrated round-robin.
- RAM read data has 1-cycle latency and is absorbed by a 2-entry output skid buffer, so pop data is registered and stall-safe.

Parameters:
- DEPTH_BIT, 6, log2 of RAM depth; DEPTH = 2**DEPTH_BIT entries.
- DATA_WIDTH, 28, entry width; must equal the RAM wrapper width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- push_valid  in  1  upstream data valid
- push_ready  out  1  controller accepts push this cycle
- push_data  in  DATA_WIDTH  entry to store
- pop_valid  out  1  head of output buffer valid
- pop_ready  in  1  downstream consumes head
- pop_data  out  DATA_WIDTH  head of output buffer
- ram_addr_w  out  DEPTH_BIT  RAM write address
- ram_addr_r  out  DEPTH_BIT  RAM read address
- ram_write_en  out  1  RAM write strobe
- ram_read_en  out  1  RAM read strobe
- ram_data_in  out  DATA_WIDTH  RAM write data (= push_data)
- ram_data_out  in  DATA_WIDTH  RAM read data, valid the cycle after ram_read_en
- fifo_cnt  out  DEPTH_BIT+1  total occupancy: RAM + in-flight + output buffer
- full  out  1  ram_cnt == DEPTH
- empty  out  1  fifo_cnt == 0

Behaviour:
- Reset values: all pointers 0; ram_cnt, fifo_cnt and ob_cnt 0; rd_inflight 0; prio_rd 0; output buffer invalid.
- Outputs under reset: pop_valid=0, ram_write_en=0, ram_read_en=0, full=0, empty=1.
- Reset mid-operation discards all contents, including an in-flight read; RAM contents are ignored afterwards.
- rd_req = (ram_cnt != 0) && (ob_cnt + rd_inflight < 2).
- push_ready = !full && !(rd_req && prio_rd). It is combinational and does not depend on push_valid.
- wr_go = push_valid && push_ready.
- rd_go = rd_req && !wr_go.
- Arbitration:
  - A conflict is push_valid && !full && rd_req in the same cycle.
  - On each conflict prio_rd toggles after the grant, so the two sides strictly alternate under sustained contention.
  - With no conflict, prio_rd holds.
- RAM strobes: ram_write_en = wr_go; ram_read_en = rd_go. They are never both 1.
- Addresses and pointers:
  - ram_addr_w = wr_ptr; ram_addr_r = rd_ptr.
  - Pointers increment on their go strobe and wrap from DEPTH-1 to 0.
- ram_cnt tracks entries written and not yet read: +1 on wr_go, -1 on rd_go, unchanged when neither occurs.
- Read return:
  - rd_inflight <= rd_go.
  - When rd_inflight=1, ram_data_out is written into the output buffer at its tail.
- Output buffer:
  - 2-entry FIFO; pop_valid = (ob_cnt != 0); pop_data = head.
  - A pop occurs on pop_valid && pop_ready.
  - The rd_req credit check guarantees the buffer never overflows.
  - Capture and pop in the same cycle keeps ob_cnt unchanged.
- fifo_cnt = ram_cnt + rd_inflight + ob_cnt. Maximum value is DEPTH+2.
- Latency with the FIFO empty:
  - push accepted in cycle t (RAM write in t)
  - read issued in t+1
  - data captured at the end of t+2
  - pop_valid=1 in t+3
- Throughput: 1 entry per 2 cycles when push and pop are both saturated, because of the single RAM port.
- Boundary conditions:
  - When full, push_ready=0 regardless of prio_rd.
  - When ram_cnt=0, no read is issued even if pop_ready=1.
  - When the output buffer is full and pop_ready=0, reads stall and a push gets the port without conflict.
  - Pop holds pop_data stable while pop_valid && !pop_ready.

Optional Feature:
- Macro: PEC_FIFO_BYPASS_EN.
- Defined:
  - A bypass path is used when push_valid && ram_cnt==0 && rd_inflight==0 && ob_cnt<2.
  - In that case push_data is written directly into the output buffer instead of RAM.
  - push_ready=1 (no arbitration), ram_write_en=0, and pop_valid rises in t+1.
  - fifo_cnt counts the bypassed entry through ob_cnt.
- Undefined: all pushes go through RAM; latency is t+3 as above.

Test Plan:
- Reset, then a single push of 0xABCDEF1 with pop_ready=1:
  - ram_write_en in t at addr 0, ram_read_en in t+1 at addr 0.
  - pop_valid=1 with pop_data=0xABCDEF1 in t+3 (t+1 with PEC_FIFO_BYPASS_EN); fifo_cnt returns to 0.
- Fill with pop_ready=0 using pushes 0..DEPTH+1:
  - The first 2 entries land in the output buffer; full=1 when ram_cnt=64; push_ready=0; fifo_cnt=66.
  - Pop all 66: data comes out in order 0..65 and ram_addr_r wraps 63→0.
- Sustained push_valid=1 and pop_ready=1 after 4 preloaded entries:
  - Grants alternate W,R,W,R; ram_write_en and ram_read_en are never both 1; order is preserved.
- Output stall: pop_ready=0 for 5 cycles with pop_valid=1:
  - pop_data is stable, ob_cnt=2, no ram_read_en is issued, pushes are still accepted each cycle.
- Assert rst for 1 cycle while a read is in flight with fifo_cnt=10:
  - The next cycle shows fifo_cnt=0, empty=1, pop_valid=0, no capture of the stale ram_data_out.
  - A subsequent push is written to addr 0.
